// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
// Module   : alu_mc
// Purpose  : Multi-cycle ALU with PSR flag register. Single-cycle logic,
//            arithmetic, shift and LUI ops complete one cycle after accept;
//            MUL is an iterative shift-add taking WIDTH+1 cycles.
// Ports    : clk, reset (async, active-high)
//            in_valid/in_ready  : operand/opcode handshake (ready only in IDLE)
//            a, b, alu_cont     : operands and opcode, sampled on accept
//            out_valid/out_ready: result handshake (valid only in DONE)
//            alu_out, wr_en, illegal : registered result and qualifiers
//            psr_flags          : {8'b0, N, Z, F, 2'b0, L, 1'b0, C}
// Config   : ALU_MC_MUL_EN - when defined, MUL (001110) datapath is built;
//            otherwise 001110 is reported as an illegal opcode.
// Revision : 1.0 - initial release
// ============================================================================
module alu_mc #(
  parameter int WIDTH         = 16,
  parameter int ALU_CONT_BITS = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  input  logic [ALU_CONT_BITS-1:0] alu_cont,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         alu_out,
  output logic                     wr_en,
  output logic                     illegal,
  output logic [15:0]              psr_flags
);

  localparam logic [ALU_CONT_BITS-1:0] OP_AND  = ALU_CONT_BITS'(6'b000001);
  localparam logic [ALU_CONT_BITS-1:0] OP_OR   = ALU_CONT_BITS'(6'b000010);
  localparam logic [ALU_CONT_BITS-1:0] OP_XOR  = ALU_CONT_BITS'(6'b000011);
  localparam logic [ALU_CONT_BITS-1:0] OP_ADD  = ALU_CONT_BITS'(6'b000101);
  localparam logic [ALU_CONT_BITS-1:0] OP_ADDU = ALU_CONT_BITS'(6'b000110);
  localparam logic [ALU_CONT_BITS-1:0] OP_SUB  = ALU_CONT_BITS'(6'b001001);
  localparam logic [ALU_CONT_BITS-1:0] OP_CMP  = ALU_CONT_BITS'(6'b001011);
  localparam logic [ALU_CONT_BITS-1:0] OP_MOV  = ALU_CONT_BITS'(6'b001101);
  localparam logic [ALU_CONT_BITS-1:0] OP_LSH  = ALU_CONT_BITS'(6'b100101);
  localparam logic [ALU_CONT_BITS-1:0] OP_ASH  = ALU_CONT_BITS'(6'b100110);
  localparam logic [ALU_CONT_BITS-1:0] OP_LUI  = ALU_CONT_BITS'(6'b111111);
`ifdef ALU_MC_MUL_EN
  localparam logic [ALU_CONT_BITS-1:0] OP_MUL  = ALU_CONT_BITS'(6'b001110);
  localparam int                       CNT_W   = $clog2(WIDTH + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DONE = 2'd1
`ifdef ALU_MC_MUL_EN
    , S_MUL = 2'd2
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic             wr_en_q, wr_en_d;
  logic             illegal_q, illegal_d;
  logic             n_q, n_d, z_q, z_d, f_q, f_d, l_q, l_d, c_q, c_d;
`ifdef ALU_MC_MUL_EN
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  // Combinational arithmetic on the live inputs; only used on the accept edge.
  logic [WIDTH:0]   add_full;
  logic [WIDTH-1:0] sub_diff;
  logic             sh_neg;
  logic [WIDTH-1:0] sh_mag;
  logic             sh_big;
  logic [WIDTH-1:0] lsh_res;
  logic [WIDTH-1:0] ash_res;

  always_comb begin
    add_full = {1'b0, a} + {1'b0, b};
    sub_diff = a - b;
    // Signed shift count: negative means shift right by its magnitude.
    // The most negative count negates to itself, which is still >= WIDTH.
    sh_neg   = b[WIDTH-1];
    sh_mag   = sh_neg ? (~b + WIDTH'(1)) : b;
    sh_big   = (sh_mag >= WIDTH'(WIDTH));
    if (sh_big)
      lsh_res = '0;
    else if (sh_neg)
      lsh_res = a >> sh_mag;
    else
      lsh_res = a << sh_mag;
    if (!sh_neg)
      ash_res = lsh_res;
    else if (sh_big)
      ash_res = {WIDTH{a[WIDTH-1]}};
    else
      ash_res = $unsigned($signed(a) >>> sh_mag);
  end

  always_comb begin
    state_d   = state_q;
    alu_out_d = alu_out_q;
    wr_en_d   = wr_en_q;
    illegal_d = illegal_q;
    n_d = n_q; z_d = z_q; f_d = f_q; l_d = l_q; c_d = c_q;
`ifdef ALU_MC_MUL_EN
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d   = S_DONE;
          wr_en_d   = 1'b1;
          illegal_d = 1'b0;
          case (alu_cont)
            OP_AND:  alu_out_d = a & b;
            OP_OR:   alu_out_d = a | b;
            OP_XOR:  alu_out_d = a ^ b;
            OP_ADD: begin
              alu_out_d = add_full[WIDTH-1:0];
              c_d       = add_full[WIDTH];
              f_d       = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (add_full[WIDTH-1] != a[WIDTH-1]);
            end
            OP_ADDU: alu_out_d = add_full[WIDTH-1:0];
            OP_SUB: begin
              alu_out_d = sub_diff;
              c_d       = (a < b);
              f_d       = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (sub_diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_CMP: begin
              alu_out_d = sub_diff;
              wr_en_d   = 1'b0;
              z_d       = (a == b);
              l_d       = (a < b);
              n_d       = ($signed(a) < $signed(b));
            end
            OP_MOV:  alu_out_d = b;
            OP_LSH:  alu_out_d = lsh_res;
            OP_ASH:  alu_out_d = ash_res;
            OP_LUI:  alu_out_d = b << (WIDTH / 2);
`ifdef ALU_MC_MUL_EN
            OP_MUL: begin
              state_d  = S_MUL;
              mcand_d  = {{WIDTH{1'b0}}, a};
              mplier_d = b;
              acc_d    = '0;
              cnt_d    = CNT_W'(WIDTH);
            end
`endif
            default: begin
              alu_out_d = '0;
              wr_en_d   = 1'b0;
              illegal_d = 1'b1;
            end
          endcase
        end
      end
`ifdef ALU_MC_MUL_EN
      S_MUL: begin
        // WIDTH shift-add iterations, then one more cycle to publish the
        // product; out_valid rises WIDTH+1 cycles after the accept edge.
        if (cnt_q != '0) begin
          if (mplier_q[0])
            acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
        end else begin
          state_d   = S_DONE;
          alu_out_d = acc_q[WIDTH-1:0];
          c_d       = |acc_q[2*WIDTH-1:WIDTH];
          wr_en_d   = 1'b1;
          illegal_d = 1'b0;
        end
      end
`endif
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      alu_out_q <= '0;
      wr_en_q   <= 1'b0;
      illegal_q <= 1'b0;
      n_q <= 1'b0; z_q <= 1'b0; f_q <= 1'b0; l_q <= 1'b0; c_q <= 1'b0;
`ifdef ALU_MC_MUL_EN
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      alu_out_q <= alu_out_d;
      wr_en_q   <= wr_en_d;
      illegal_q <= illegal_d;
      n_q <= n_d; z_q <= z_d; f_q <= f_d; l_q <= l_d; c_q <= c_d;
`ifdef ALU_MC_MUL_EN
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign alu_out   = alu_out_q;
  assign wr_en     = wr_en_q;
  assign illegal   = illegal_q;
  assign psr_flags = {8'b0, n_q, z_q, f_q, 2'b0, l_q, 1'b0, c_q};

endmodule
`default_nettype wire
